// File: rtl/fluxo_dados_sequencia.sv
// Datapath for the sequence-memory game: address and limit counters, a
// jogada register, a writable one-hot-initialised sequence memory, a key
// press edge detector and a saturating per-move timeout counter.
module fluxo_dados_sequencia #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 5000,
  parameter int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              zeraE,
  input  logic              contaE,
  input  logic              zeraL,
  input  logic              contaL,
  input  logic              zeraR,
  input  logic              registraR,
  input  logic              zeraT,
  input  logic              contaT,
  input  logic              escreveM,
  input  logic [WIDTH-1:0]  chaves,
  output logic              igual,
  output logic              enderecoIgualLimite,
  output logic              fimE,
  output logic              fimL,
  output logic              jogada_feita,
  output logic              timeout,
  output logic              db_tem_jogada,
  output logic [ADDR_W-1:0] db_contagem,
  output logic [ADDR_W-1:0] db_limite,
  output logic [WIDTH-1:0]  db_memoria,
  output logic [WIDTH-1:0]  db_jogada
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [TW-1:0]     LAST_T    = TW'(TIMEOUT - 1);

  logic [ADDR_W-1:0] endereco_r;
  logic [ADDR_W-1:0] limite_r;
  logic [WIDTH-1:0]  jogada_r;
  logic [TW-1:0]     tempo_r;
  logic [WIDTH-1:0]  mem_r [DEPTH];
  logic              tecla_s;
  logic              tecla_prev_r;
  logic              armado_r;
  logic              jogada_feita_r;
  logic [WIDTH-1:0]  mem_rd_s;

  assign tecla_s  = |chaves;
  assign mem_rd_s = mem_r[endereco_r];

  // Address counter: clear beats count, wraps at DEPTH-1 even for non-power-of-two depths.
  always_ff @(posedge clock) begin
    if (reset) begin
      endereco_r <= '0;
    end else if (zeraE) begin
      endereco_r <= '0;
    end else if (contaE) begin
      if (endereco_r == LAST_ADDR) begin
        endereco_r <= '0;
      end else begin
        endereco_r <= endereco_r + ADDR_W'(1);
      end
    end else begin
      endereco_r <= endereco_r;
    end
  end

  // Limit counter for progressive rounds, same wrap rule as the address counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      limite_r <= '0;
    end else if (zeraL) begin
      limite_r <= '0;
    end else if (contaL) begin
      if (limite_r == LAST_ADDR) begin
        limite_r <= '0;
      end else begin
        limite_r <= limite_r + ADDR_W'(1);
      end
    end else begin
      limite_r <= limite_r;
    end
  end

  // Jogada register captures the keys on registraR.
  always_ff @(posedge clock) begin
    if (reset) begin
      jogada_r <= '0;
    end else if (zeraR) begin
      jogada_r <= '0;
    end else if (registraR) begin
      jogada_r <= chaves;
    end else begin
      jogada_r <= jogada_r;
    end
  end

  // Sequence memory: reset loads a one-hot walking pattern; writes use pre-edge jogada and address.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= WIDTH'(1) << (i % WIDTH);
      end
    end else if (escreveM) begin
      mem_r[endereco_r] <= jogada_r;
    end else begin
      mem_r[endereco_r] <= mem_r[endereco_r];
    end
  end

  // Per-move timeout counter, saturating at TIMEOUT-1 instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      tempo_r <= '0;
    end else if (zeraT) begin
      tempo_r <= '0;
    end else if (contaT && (tempo_r != LAST_T)) begin
      tempo_r <= tempo_r + TW'(1);
    end else begin
      tempo_r <= tempo_r;
    end
  end

  // Press edge detector; the arm flag keeps a key held through reset from
  // producing a pulse until it has been released at least once.
  always_ff @(posedge clock) begin
    if (reset) begin
      tecla_prev_r   <= 1'b0;
      armado_r       <= 1'b0;
      jogada_feita_r <= 1'b0;
    end else begin
      tecla_prev_r   <= tecla_s;
      armado_r       <= armado_r | ~tecla_s;
      jogada_feita_r <= tecla_s & ~tecla_prev_r & armado_r;
    end
  end

  assign igual               = (mem_rd_s == jogada_r);
  assign enderecoIgualLimite = (endereco_r == limite_r);
  assign fimE                = (endereco_r == LAST_ADDR);
  assign fimL                = (limite_r == LAST_ADDR);
  assign jogada_feita        = jogada_feita_r;
  assign timeout             = (tempo_r == LAST_T);
  assign db_tem_jogada       = tecla_s;
  assign db_contagem         = endereco_r;
  assign db_limite           = limite_r;
  assign db_memoria          = mem_rd_s;
  assign db_jogada           = jogada_r;

endmodule
